comm_master: RTL

COMM_MASTER -- requirements
Module: comm_master

---
 rtl/comm_pkg.sv | 23 ++
 rtl/comm_master_uart_tx.sv | 67 ++++++
 rtl/comm_master.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// ============================================================================
// Module   : comm_pkg
// Purpose  : Shared state encoding and framing constant for comm_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package comm_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND_CMD  = 3'd1,
      SEND_HI   = 3'd2,
      SEND_LO   = 3'd3,
      WAIT_RESP = 3'd4
   } state_t;

   // Start bit + 8 data bits + stop bit.
   localparam int unsigned c_frame_bits = 10;

endpackage

`default_nettype wire

// File: rtl/comm_master_uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 serialiser, one frame per trmt pulse, tx_done at stop-bit end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
   import comm_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       tx_done
);

   localparam int unsigned c_baud_w = $clog2(BAUD_DIV + 1);

   logic [c_frame_bits-1:0] r_shift;
   logic [c_baud_w-1:0]     r_baud_cnt;
   logic [3:0]              r_bit_cnt;
   logic                    r_active;
   logic                    r_done;

   // The line is the LSB of the shift register, which rests at all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift    <= '1;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (!r_active) begin
            if (trmt) begin
               r_shift    <= {1'b1, tx_data, 1'b0};
               r_active   <= 1'b1;
               r_baud_cnt <= '0;
               r_bit_cnt  <= '0;
            end
         end else if (r_baud_cnt == c_baud_w'(BAUD_DIV - 1)) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 4'(c_frame_bits - 1)) begin
               r_active <= 1'b0;
               r_done   <= 1'b1;
               r_shift  <= '1;
            end else begin
               r_shift   <= {1'b1, r_shift[c_frame_bits-1:1]};
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
         end else begin
            r_baud_cnt <= r_baud_cnt + c_baud_w'(1);
         end
      end
   end

   assign TX      = r_shift[0];
   assign tx_done = r_done;

endmodule

`default_nettype wire

// File: rtl/comm_master.sv
// ============================================================================
// Module   : comm_master
// Purpose  : Sends cmd + 16-bit payload as three 8N1 bytes, then waits for a
//            one-byte response. Define COMM_RESP_TIMEOUT_EN for a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comm_master
   import comm_pkg::*;
#(
   parameter int unsigned BAUD_DIV     = 2604,
   parameter int unsigned RESP_TIMEOUT = 5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        snd_cmd,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   output logic        TX,
   output logic        cmd_sent,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   output logic [7:0]  resp,
   output logic        resp_rdy,
   output logic        busy,
   output logic        timeout
);

   state_t      r_state;
   logic [15:0] r_data;
   logic [7:0]  r_tx_byte;
   logic        r_trmt;
   logic        r_cmd_sent;
   logic        r_clr_rx_rdy;
   logic [7:0]  r_resp;
   logic        r_resp_rdy;
   logic        r_busy;
   logic        w_tx_done;

`ifdef COMM_RESP_TIMEOUT_EN
   localparam int unsigned c_wait_w = $clog2(RESP_TIMEOUT + 1);
   logic [c_wait_w-1:0] r_wait_cnt;
   logic                r_timeout;
`endif

   uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
      .clk     (clk),
      .rst     (rst),
      .trmt    (r_trmt),
      .tx_data (r_tx_byte),
      .TX      (TX),
      .tx_done (w_tx_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_data       <= '0;
         r_tx_byte    <= '0;
         r_trmt       <= 1'b0;
         r_cmd_sent   <= 1'b0;
         r_clr_rx_rdy <= 1'b0;
         r_resp       <= 8'h00;
         r_resp_rdy   <= 1'b0;
         r_busy       <= 1'b0;
`ifdef COMM_RESP_TIMEOUT_EN
         r_wait_cnt   <= '0;
         r_timeout    <= 1'b0;
`endif
      end else begin
         r_trmt       <= 1'b0;
         r_cmd_sent   <= 1'b0;
         r_clr_rx_rdy <= 1'b0;
         case (r_state)
            IDLE: begin
               if (snd_cmd) begin
                  r_tx_byte  <= cmd;
                  r_data     <= data;
                  r_trmt     <= 1'b1;
                  r_resp_rdy <= 1'b0;
                  r_busy     <= 1'b1;
`ifdef COMM_RESP_TIMEOUT_EN
                  r_timeout  <= 1'b0;
`endif
                  r_state    <= SEND_CMD;
               end
            end
            SEND_CMD: begin
               if (w_tx_done) begin
                  r_tx_byte <= r_data[15:8];
                  r_trmt    <= 1'b1;
                  r_state   <= SEND_HI;
               end
            end
            SEND_HI: begin
               if (w_tx_done) begin
                  r_tx_byte <= r_data[7:0];
                  r_trmt    <= 1'b1;
                  r_state   <= SEND_LO;
               end
            end
            SEND_LO: begin
               if (w_tx_done) begin
                  r_cmd_sent <= 1'b1;
`ifdef COMM_RESP_TIMEOUT_EN
                  r_wait_cnt <= '0;
`endif
                  r_state    <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               // A response arriving on the final count still wins.
               if (rx_rdy) begin
                  r_resp       <= rx_data;
                  r_clr_rx_rdy <= 1'b1;
                  r_resp_rdy   <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= IDLE;
               end
`ifdef COMM_RESP_TIMEOUT_EN
               else if (r_wait_cnt == c_wait_w'(RESP_TIMEOUT - 1)) begin
                  r_timeout <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
               end
`endif
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign cmd_sent   = r_cmd_sent;
   assign clr_rx_rdy = r_clr_rx_rdy;
   assign resp       = r_resp;
   assign resp_rdy   = r_resp_rdy;
   assign busy       = r_busy;
`ifdef COMM_RESP_TIMEOUT_EN
   assign timeout    = r_timeout;
`else
   assign timeout    = 1'b0;
`endif

endmodule

`default_nettype wire
